// File: rtl/bshift_pkg.sv
// ---------------------------------------------------------------------------
// bshift_pkg
// Shared types and constants for the sequential barrel-shift controller.
//   state_t        : controller FSM states (IDLE / SHIFT / DONE)
//   calc_shamt_w() : rotate-amount width for a given data width
//   DIR_RIGHT/LEFT : encodings of the in_dir request field
// ---------------------------------------------------------------------------
package bshift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    // Width needed to encode a rotate amount 0..data_w-1.
    function automatic int calc_shamt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/bshift_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bshift_seq_ctrl_if
// Request/result handshake bundle of the sequential rotate controller.
//   in_valid/in_ready   : request handshake, carries in_data/in_shamt/in_dir
//   out_valid/out_ready : result handshake, carries out_data
// Modports:
//   master : request source / result consumer side
//   slave  : controller side
// ---------------------------------------------------------------------------
interface bshift_seq_ctrl_if
    import bshift_pkg::*;
#(
    parameter int DATA_W = 32
);
    localparam int SHAMT_W = calc_shamt_w(DATA_W);

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_dir;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/bshift_rot_stage.sv
// ---------------------------------------------------------------------------
// bshift_rot_stage
// Single combinational rotate stage shared by every step of the sequence.
//   data_in  : operand
//   amt      : rotate distance k (a power of two chosen at run time)
//   dir      : DIR_RIGHT / DIR_LEFT
//   ena      : 0 passes data_in through unchanged
//   data_out : rotated operand, same width as data_in
// ---------------------------------------------------------------------------
module bshift_rot_stage
    import bshift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = calc_shamt_w(DATA_W)
) (
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               dir,
    input  logic               ena,
    output logic [DATA_W-1:0]  data_out
);
    // Complementary distance W-k; one extra bit so W itself is representable.
    // For k=0 the complementary shift is by W and contributes nothing.
    logic [SHAMT_W:0] inv_amt;

    assign inv_amt = (SHAMT_W+1)'(DATA_W) - {1'b0, amt};

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        data_out = data_in;
        if (ena) begin
            case (dir)
                DIR_RIGHT: data_out = (data_in >> amt) | (data_in << inv_amt);
                DIR_LEFT:  data_out = (data_in << amt) | (data_in >> inv_amt);
                default:   data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/bshift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bshift_seq_ctrl
// Multi-cycle rotate controller: accepts one rotate request, then drives a
// single shared rotate stage one log2 step per clock and holds the result
// until the consumer takes it. One request in flight at a time.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort, drops any in-flight or held result
//   bus   : bshift_seq_ctrl_if.slave (request and result handshakes)
//   busy  : high whenever the FSM is not IDLE
// Build option:
//   BSHIFT_SKIP_ZERO_EN : when defined, each SHIFT cycle applies only the
//     lowest set bit of the remaining amount, so latency is
//     max(1, popcount(shamt)) instead of a fixed SHAMT_W cycles.
// ---------------------------------------------------------------------------
module bshift_seq_ctrl
    import bshift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    bshift_seq_ctrl_if.slave        bus,
    output logic                    busy
);
    localparam int SHAMT_W = calc_shamt_w(DATA_W);

    state_t             state_q,     state_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic [SHAMT_W-1:0] shamt_q,     shamt_d;
    logic               dir_q,       dir_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic [SHAMT_W-1:0] stage_k;
    logic               stage_ena;
    logic [DATA_W-1:0]  stage_out;

    assign in_ready      = (state_q == IDLE) && !clr;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy          = (state_q != IDLE);

`ifdef BSHIFT_SKIP_ZERO_EN
    // Lowest set bit of the remaining amount is this cycle's stage distance.
    assign stage_k   = shamt_q & (~shamt_q + SHAMT_W'(1));
    assign stage_ena = (state_q == SHIFT) && (shamt_q != '0);
`else
    logic [SHAMT_W-1:0] step_q, step_d;

    assign stage_k   = SHAMT_W'(1) << step_q;
    assign stage_ena = (state_q == SHIFT) && shamt_q[step_q];
`endif

    bshift_rot_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_rot (
        .data_in  (data_q),
        .amt      (stage_k),
        .dir      (dir_q),
        .ena      (stage_ena),
        .data_out (stage_out)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            shamt_q     <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifndef BSHIFT_SKIP_ZERO_EN
            step_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shamt_q     <= shamt_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
`ifndef BSHIFT_SKIP_ZERO_EN
            step_q      <= step_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
`ifndef BSHIFT_SKIP_ZERO_EN
        step_d      = step_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    data_d  = bus.in_data;
                    shamt_d = bus.in_shamt;
                    dir_d   = bus.in_dir;
`ifndef BSHIFT_SKIP_ZERO_EN
                    step_d  = '0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = stage_out;
`ifdef BSHIFT_SKIP_ZERO_EN
                // Clear the bit just applied; an all-zero amount finishes at once.
                shamt_d = shamt_q & (shamt_q - SHAMT_W'(1));
                if (shamt_d == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
`else
                step_d = step_q + SHAMT_W'(1);
                if (step_q == SHAMT_W'(SHAMT_W - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over both the accept and the result handshake.
        if (clr) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_bshift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bshift_seq_ctrl
// Randomized and directed bench for bshift_seq_ctrl. Expected results come
// from a bit-at-a-time rotate model; expected latency from the amount alone.
// Honors BSHIFT_SKIP_ZERO_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bshift_seq_ctrl;
    localparam int W  = 32;
    localparam int SW = $clog2(W);

    logic clk;
    logic rst_n;
    logic clr;
    logic busy;

    int errors = 0;
    int checks = 0;

    bshift_seq_ctrl_if #(.DATA_W(W)) bus ();

    bshift_seq_ctrl #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rotate one bit position at a time, n times.
    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d, input int n, input logic dir);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < n; i++)
            r = dir ? {r[0], r[W-1:1]} : {r[W-2:0], r[W-1]};
        return r;
    endfunction

    function automatic int exp_latency(input int shamt);
`ifdef BSHIFT_SKIP_ZERO_EN
        int pc;
        pc = 0;
        for (int i = 0; i < SW; i++)
            if (((shamt >> i) & 1) == 1) pc++;
        return (pc == 0) ? 1 : pc;
`else
        return (shamt >= 0) ? SW : SW;
`endif
    endfunction

    // One full transaction. Starts and ends one time unit after a rising edge.
    // hold: cycles the consumer stalls; poke: present a competing request during the stall.
    task automatic run_req(input logic [W-1:0] d, input int sh, input logic dir,
                           input int hold, input bit poke, input string tag,
                           output logic [W-1:0] got);
        logic [W-1:0] exp;
        int lat;
        exp = rot_ref(d, sh, dir);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = SW'(sh);
        bus.in_dir   = dir;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_shamt = SW'($urandom);
        bus.in_dir   = 1'($urandom);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_accept: got busy=%b in_ready=%b want 1/0", tag, busy, bus.in_ready);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_latency(sh)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_latency(sh));
        end
        checks++;
        if (bus.out_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h (shamt=%0d dir=%b)", tag, bus.out_data, exp, sh, dir);
        end
        got = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.in_data  = ~d;
                bus.in_shamt = SW'(i + 1);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: got valid=%b data=%h in_ready=%b want 1/%h/0",
                         tag, i, bus.out_valid, bus.out_data, bus.in_ready, exp);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b busy=%b in_ready=%b want 0/0/1",
                     tag, bus.out_valid, busy, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got in_ready=%b out_valid=%b busy=%b out_data=%h want 1/0/0/0",
                     bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] got;
        run_req(32'h12345678, 4, 1'b1, 0, 1'b0, "ror4", got);
        checks++;
        if (got !== 32'h81234567) begin
            errors++;
            $display("FAIL ror4_literal: got %h want 81234567", got);
        end
        run_req(32'h80000001, 1, 1'b0, 0, 1'b0, "rol1", got);
        checks++;
        if (got !== 32'h00000003) begin
            errors++;
            $display("FAIL rol1_literal: got %h want 00000003", got);
        end
        run_req(32'h80000001, 31, 1'b1, 0, 1'b0, "ror31", got);
        checks++;
        if (got !== 32'h00000003) begin
            errors++;
            $display("FAIL ror31_literal: got %h want 00000003", got);
        end
    endtask

    task automatic test_zero_hold();
        logic [W-1:0] got;
        run_req(32'hDEADBEEF, 0, 1'b0, 3, 1'b1, "zero_hold", got);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL zero_literal: got %h want deadbeef", got);
        end
    endtask

    task automatic test_clr();
        logic [W-1:0] got;
        int rose;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA5A5_0F0F;
        bus.in_shamt = SW'(31);
        bus.in_dir   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_abort: got busy=%b valid=%b in_ready=%b want 0/0/0",
                     busy, bus.out_valid, bus.in_ready);
        end
        // clr must also block an accept presented in IDLE.
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_blocks_accept: got busy=%b want 0", busy);
        end
        rose = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) rose++;
        end
        checks++;
        if (rose != 0) begin
            errors++;
            $display("FAIL clr_no_valid: got %0d valid cycles want 0", rose);
        end
        run_req(32'h0000_00F0, 8, 1'b0, 0, 1'b0, "after_clr", got);
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_1234;
        bus.in_shamt = SW'(31);
        bus.in_dir   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got in_ready=%b valid=%b busy=%b data=%h want 1/0/0/0",
                     bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(32'h0F00_00FF, 12, 1'b1, 1, 1'b0, "after_rst", got);
    endtask

    task automatic test_random();
        logic [W-1:0] got;
        for (int n = 0; n < 40; n++)
            run_req($urandom, int'($urandom_range(W - 1, 0)), 1'($urandom),
                    int'($urandom_range(2, 0)), 1'($urandom), "random", got);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got;
        run_req(32'h0000_0001, 16, 1'b0, 0, 1'b0, "b2b_a", got);
        run_req(32'h0000_0001, 31, 1'b0, 0, 1'b0, "b2b_b", got);
        run_req(32'hFFFF_0000, 5, 1'b1, 0, 1'b0, "b2b_c", got);
    endtask

    task automatic test_skip_latency();
        logic [W-1:0] got;
        run_req(32'h1357_9BDF, 16, 1'b1, 0, 1'b0, "lat_16", got);
        run_req(32'h1357_9BDF, 31, 1'b0, 0, 1'b0, "lat_31", got);
        run_req(32'h1357_9BDF, 0, 1'b1, 0, 1'b0, "lat_0", got);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_hold();
        test_clr();
        test_async_reset();
        test_random();
        test_back_to_back();
        test_skip_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
